// File: rtl/acc_requant_pack.sv
// acc_requant_pack: drains one tile of int32 accumulators from the PE array,
// requantises each to int8 (bias, scale, rounding shift, zero point, saturate)
// and packs four results per 32-bit word into an output FIFO.
// Handshake: a word moves on o_valid && o_ready; once o_valid is high, o_data and
// o_last hold until that transfer. The drain stream has no backpressure, so a
// drain is requested only when the FIFO can take the whole tile.
module acc_requant_pack #(
  parameter int SIDE       = 8,
  parameter int ACC_BITS   = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int IDX_W     = $clog2(SIDE)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tile_go,
  input  logic [15:0]         cfg_scale,
  input  logic [5:0]          cfg_shift,
  input  logic [7:0]          cfg_zp,
  input  logic                bias_wr_en,
  input  logic [IDX_W-1:0]    bias_wr_idx,
  input  logic [31:0]         bias_wr_data,
  output logic                c_drain_req,
  input  logic                c_busy,
  input  logic                c_valid,
  input  logic [ACC_BITS-1:0] c_data,
  input  logic                c_last,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [31:0]         o_data,
  output logic                o_last,
  output logic                busy,
  output logic                err,
  output logic [1:0]          dbg_state_o
);

  localparam int TILE   = SIDE * SIDE;
  localparam int WORDS  = TILE / 4;
  localparam int CNT_W  = $clog2(TILE) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int S1_W   = ACC_BITS + 1;
  localparam int S2_W   = ACC_BITS + 17;
  localparam int S3_W   = ACC_BITS + 18;

  typedef enum logic [1:0] {IDLE, REQ, RECV, FLUSH} state_t;

  state_t                   state_q, state_d;
  logic                     pend_q, err_q;
  logic signed [15:0]       scale_q;
  logic [5:0]               shift_q;
  logic [7:0]               zp_q;
  logic [IDX_W-1:0]         col_q;
  logic [CNT_W-1:0]         beat_q;
  logic [31:0]              bias_q [SIDE];

  logic                     v1_q, last1_q, v2_q, last2_q, v3_q, last3_q;
  logic signed [S1_W-1:0]   s1_q;
  logic signed [S2_W-1:0]   s2_q;
  logic [7:0]               b3_q;
  logic [1:0]               lane_q;
  logic [23:0]              pack_q;

  logic [32:0]              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wptr_q, rptr_q;
  logic [FCNT_W-1:0]        cnt_q;

  logic                     accept_go, beat, push, pop, full, wr, overflow;
  logic signed [S1_W-1:0]   s1_d;
  logic signed [S2_W-1:0]   s1e, sce, s2_d;
  logic signed [S3_W-1:0]   s2x, rnd, s3, s4;
  logic                     pos_ovf, neg_ovf;
  logic [7:0]               byte_d;
  logic [31:0]              push_word;

  // Tile acceptance, beat qualification and FIFO flags.
  always_comb begin
    accept_go = (state_q == IDLE) && (pend_q || tile_go) &&
                (cnt_q <= FCNT_W'(FIFO_DEPTH - WORDS));
    beat      = c_valid && (state_q == RECV);
    full      = (cnt_q == FCNT_W'(FIFO_DEPTH));
    pop       = o_valid && o_ready;
    push      = v3_q && ((lane_q == 2'd3) || last3_q);
    wr        = push && (!full || pop);
    overflow  = push && full && !pop;
  end

  // Next-state logic for the drain sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_go) state_d = REQ;
      REQ:     if (c_busy) state_d = RECV;
      RECV:    if (beat && c_last) state_d = FLUSH;
      FLUSH:   if (!v1_q && !v2_q && !v3_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, pending flag, sticky error, latched config and beat counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      scale_q <= '0;
      shift_q <= '0;
      zp_q    <= '0;
      col_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= accept_go ? (pend_q && tile_go) : (pend_q || tile_go);
      if ((tile_go && pend_q && !accept_go) || (c_valid && state_q != RECV) ||
          (beat && c_last && beat_q != CNT_W'(TILE - 1)) || overflow)
        err_q <= 1'b1;
      if (accept_go) begin
        scale_q <= cfg_scale;
        shift_q <= cfg_shift;
        zp_q    <= cfg_zp;
        col_q   <= '0;
        beat_q  <= '0;
      end else if (beat) begin
        col_q <= (col_q == IDX_W'(SIDE - 1)) ? '0 : col_q + 1'b1;
        if (beat_q != '1) beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Per-column bias table, writable at any time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SIDE; i++) bias_q[i] <= '0;
    end else if (bias_wr_en) begin
      bias_q[bias_wr_idx] <= bias_wr_data;
    end
  end

  // Requantisation arithmetic: bias add, scale multiply, round/shift, zp, saturate.
  always_comb begin
    s1_d    = {c_data[ACC_BITS-1], c_data} +
              {{(S1_W-32){bias_q[col_q][31]}}, bias_q[col_q]};
    s1e     = {{16{s1_q[S1_W-1]}}, s1_q};
    sce     = {{S1_W{scale_q[15]}}, scale_q};
    s2_d    = s1e * sce;
    s2x     = {s2_q[S2_W-1], s2_q};
    rnd     = (shift_q == 6'd0) ? '0 : (S3_W'(1) << (shift_q - 6'd1));
    s3      = (s2x + rnd) >>> shift_q;
    s4      = s3 + {{(S3_W-8){zp_q[7]}}, zp_q};
    pos_ovf = !s4[S3_W-1] && (|s4[S3_W-2:7]);
    neg_ovf = s4[S3_W-1] && !(&s4[S3_W-2:7]);
    byte_d  = pos_ovf ? 8'h7F : (neg_ovf ? 8'h80 : s4[7:0]);
  end

  // Three-stage pipeline: s1, s2, saturated byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0; last1_q <= 1'b0; s1_q <= '0;
      v2_q <= 1'b0; last2_q <= 1'b0; s2_q <= '0;
      v3_q <= 1'b0; last3_q <= 1'b0; b3_q <= '0;
    end else begin
      v1_q <= beat;  last1_q <= beat && c_last; s1_q <= s1_d;
      v2_q <= v1_q;  last2_q <= last1_q;        s2_q <= s2_d;
      v3_q <= v2_q;  last3_q <= last2_q;        b3_q <= byte_d;
    end
  end

  // Byte packer: lanes 0..2 accumulate; lane 3 or the tile's last beat emits a word.
  assign push_word = {8'h00, pack_q} | ({24'h0, b3_q} << {lane_q, 3'b000});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q <= '0;
      pack_q <= '0;
    end else if (v3_q) begin
      if (push) begin
        lane_q <= '0;
        pack_q <= '0;
      end else begin
        lane_q <= lane_q + 1'b1;
        pack_q[8*lane_q +: 8] <= b3_q;
      end
    end
  end

  // Output FIFO: {last, data} entries; simultaneous push and pop keep occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) begin
        mem_q[wptr_q] <= {last3_q, push_word};
        wptr_q <= (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) rptr_q <= (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign c_drain_req = (state_q == REQ);
  assign o_valid     = (cnt_q != '0);
  assign o_data      = mem_q[rptr_q][31:0];
  assign o_last      = mem_q[rptr_q][32];
  assign busy        = (state_q != IDLE) || pend_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acc_requant_pack.sv
// Testbench for acc_requant_pack: drives tiles through a drain-stream model,
// predicts packed words from the requantisation rules and scoreboards them.
module tb_acc_requant_pack;

  localparam int SIDE = 8;
  localparam int TILE = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tile_go = 1'b0;
  logic [15:0] cfg_scale = '0;
  logic [5:0]  cfg_shift = '0;
  logic [7:0]  cfg_zp = '0;
  logic        bias_wr_en = 1'b0;
  logic [2:0]  bias_wr_idx = '0;
  logic [31:0] bias_wr_data = '0;
  logic        c_drain_req;
  logic        c_busy = 1'b0;
  logic        c_valid = 1'b0;
  logic [31:0] c_data = '0;
  logic        c_last = 1'b0;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_last;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 2;
  bit          sb_off = 1'b0;
  int          beat3_cyc = 0;
  int          first_v_cyc = -1;
  int          bias_m [SIDE];
  int          tdata [TILE];
  logic [31:0] exp_q [$];
  logic        exp_last_q [$];
  logic [31:0] rx_q [$];
  logic        rx_last_q [$];

  acc_requant_pack dut (
    .clk(clk), .rstn(rstn), .tile_go(tile_go),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
    .bias_wr_en(bias_wr_en), .bias_wr_idx(bias_wr_idx), .bias_wr_data(bias_wr_data),
    .c_drain_req(c_drain_req), .c_busy(c_busy), .c_valid(c_valid),
    .c_data(c_data), .c_last(c_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .busy(busy), .err(err), .dbg_state_o(dbg_state)
  );

  // Clock, cycle counter and watchdog.
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // o_ready driver: 0 = stalled, 1 = random, 2 = always ready.
  initial begin
    o_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       o_ready = 1'b0;
        1:       o_ready = 1'($urandom_range(0, 1));
        default: o_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard on transfers, stability while stalled.
  initial begin
    logic        prev_stall;
    logic [32:0] prev_word;
    prev_stall = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", o_valid, 1);
          chk("hold_word", {o_last, o_data}, prev_word);
        end
        if (o_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (o_valid && o_ready && !sb_off) begin
          chk("sb_extra_word", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            chk("sb_word", o_data, exp_q.pop_front());
            chk("sb_last", o_last, exp_last_q.pop_front());
          end
          rx_q.push_back(o_data);
          rx_last_q.push_back(o_last);
        end
        prev_stall = o_valid && !o_ready;
        prev_word = {o_last, o_data};
      end
    end
  end

  // Reference requantisation of one accumulator, straight from the arithmetic rules.
  function automatic logic [7:0] ref_byte(longint acc, longint b, longint sc, int sh, longint zp);
    longint s;
    s = (acc + b) * sc;
    if (sh != 0) s = (s + (longint'(1) <<< (sh - 1))) >>> sh;
    s = s + zp;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s[7:0];
  endfunction

  // Predict the words of an n-beat tile from tdata, bias_m and the current cfg.
  task automatic model_tile(input int n);
    logic [31:0] w;
    int lane;
    w = '0;
    lane = 0;
    for (int i = 0; i < n; i++) begin
      w[8*lane +: 8] = ref_byte(longint'(tdata[i]), longint'(bias_m[i % SIDE]),
                                longint'($signed(cfg_scale)), int'(cfg_shift),
                                longint'($signed(cfg_zp)));
      lane++;
      if (lane == 4 || i == n - 1) begin
        exp_q.push_back(w);
        exp_last_q.push_back(i == n - 1);
        w = '0;
        lane = 0;
      end
    end
  endtask

  task automatic set_cfg(input int sc, input int sh, input int zp);
    cfg_scale = sc[15:0];
    cfg_shift = sh[5:0];
    cfg_zp = zp[7:0];
  endtask

  task automatic write_bias(input int idx, input int val);
    bias_wr_en = 1'b1;
    bias_wr_idx = idx[2:0];
    bias_wr_data = val;
    tick();
    bias_wr_en = 1'b0;
    bias_m[idx] = val;
  endtask

  task automatic pulse_go();
    tile_go = 1'b1;
    tick();
    tile_go = 1'b0;
  endtask

  // Array drain model: answer c_drain_req with c_busy, then stream n beats.
  // abort_at >= 0 pulls reset at that beat instead of sending it.
  task automatic feed_tile(input int n, input int abort_at);
    int t;
    if (abort_at < 0) model_tile(n);
    t = 0;
    while (!c_drain_req && t < 400) begin tick(); t++; end
    chk("drain_req_seen", c_drain_req, 1);
    if (!c_drain_req) return;
    c_busy = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin rstn = 1'b0; break; end
      c_valid = 1'b1;
      c_data = tdata[i];
      c_last = (i == n - 1);
      if (i == 3) beat3_cyc = cyc;
      tick();
    end
    c_valid = 1'b0;
    c_last = 1'b0;
    c_busy = 1'b0;
    c_data = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || o_valid) && t < 1500) begin tick(); t++; end
    chk("drain_complete", exp_q.size(), 0);
    chk("drain_idle", busy, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    exp_q.delete(); exp_last_q.delete(); rx_q.delete(); rx_last_q.delete();
    for (int c = 0; c < SIDE; c++) bias_m[c] = 0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_drain_req"}, c_drain_req, 0);
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_o_data"}, o_data, 0);
    chk({tag, "_o_last"}, o_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Directed sequence.
  initial begin
    bit saw_req;
    for (int c = 0; c < SIDE; c++) bias_m[c] = 0;
    rstn = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // Identity: words 0x03020100 .. 0x3F3E3D3C, latency 4 from beat 3.
    rdy_mode = 2;
    set_cfg(1, 0, 0);
    for (int i = 0; i < TILE; i++) tdata[i] = i;
    first_v_cyc = -1;
    pulse_go();
    chk("req_at_t1", c_drain_req, 1);
    feed_tile(TILE, -1);
    wait_drain();
    chk("id_count", rx_q.size(), 16);
    chk("id_first", rx_q[0], 32'h03020100);
    chk("id_lastword", rx_q[15], 32'h3F3E3D3C);
    chk("id_lastflag", rx_last_q[15], 1);
    chk("id_latency", first_v_cyc - beat3_cyc, 4);

    // Rounding and saturation.
    rx_q.delete(); rx_last_q.delete();
    set_cfg(3, 2, -5);
    for (int i = 0; i < TILE; i++) begin
      case (i % 4)
        0: tdata[i] = 5;
        1: tdata[i] = -5;
        2: tdata[i] = 1000;
        default: tdata[i] = -1000;
      endcase
    end
    pulse_go();
    feed_tile(TILE, -1);
    wait_drain();
    chk("rnd_word", rx_q[0], 32'h807FF7FF);

    // Per-column bias.
    rx_q.delete(); rx_last_q.delete();
    for (int c = 0; c < SIDE; c++) write_bias(c, 10 * c);
    set_cfg(1, 0, 0);
    for (int i = 0; i < TILE; i++) tdata[i] = 0;
    pulse_go();
    feed_tile(TILE, -1);
    wait_drain();
    chk("bias_w0", rx_q[0], 32'h1E140A00);
    chk("bias_w1", rx_q[1], 32'h463C3228);
    chk("bias_w14", rx_q[14], 32'h1E140A00);

    // Random tiles with random bias, config and o_ready.
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < SIDE; c++)
        write_bias(c, ($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 600)) - 300);
      set_cfg(int'($urandom_range(0, 65535)),
              (k == 2) ? int'($urandom_range(17, 47)) : int'($urandom_range(0, 16)),
              int'($urandom_range(0, 255)));
      for (int i = 0; i < TILE; i++)
        tdata[i] = ($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
      pulse_go();
      feed_tile(TILE, -1);
      wait_drain();
    end

    // Backpressure: tile 2 waits until the FIFO has room for a whole tile.
    rx_q.delete(); rx_last_q.delete();
    for (int c = 0; c < SIDE; c++) write_bias(c, 0);
    rdy_mode = 0;
    set_cfg(1, 0, 0);
    for (int i = 0; i < TILE; i++) tdata[i] = i + 20;
    pulse_go();
    feed_tile(TILE, -1);
    repeat (8) tick();
    chk("bp_full_valid", o_valid, 1);
    pulse_go();
    saw_req = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (c_drain_req) saw_req = 1'b1;
      tick();
    end
    chk("bp_no_req", saw_req, 0);
    chk("bp_pending_busy", busy, 1);
    for (int i = 0; i < TILE; i++) tdata[i] = 100 - i;
    rdy_mode = 1;
    feed_tile(TILE, -1);
    wait_drain();
    chk("bp_word_count", rx_q.size(), 32);
    chk("bp_err", err, 0);

    // Protocol error: tile_go while already pending.
    rdy_mode = 2;
    do_reset();
    pulse_go();
    pulse_go();
    chk("err_single_pend", err, 0);
    pulse_go();
    chk("err_double_go", err, 1);

    // Protocol error: c_valid while IDLE, no push.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      c_valid = 1'b1;
      c_data = i;
      tick();
    end
    c_valid = 1'b0;
    chk("err_valid_idle", err, 1);
    repeat (8) tick();
    chk("idle_beats_dropped", o_valid, 0);

    // Protocol error: short tile of 62 beats.
    do_reset();
    set_cfg(1, 0, 0);
    for (int i = 0; i < TILE; i++) tdata[i] = i;
    pulse_go();
    feed_tile(62, -1);
    wait_drain();
    chk("short_err", err, 1);
    chk("short_count", rx_q.size(), 16);
    chk("short_lastword", rx_q[15], 32'h00003D3C);
    chk("short_lastflag", rx_last_q[15], 1);

    // Reset mid-tile, then a fresh tile.
    do_reset();
    sb_off = 1'b1;
    pulse_go();
    feed_tile(TILE, 20);
    #1;
    chk_reset_outputs("midrst");
    tick();
    rstn = 1'b1;
    exp_q.delete(); exp_last_q.delete(); rx_q.delete(); rx_last_q.delete();
    sb_off = 1'b0;
    tick();
    pulse_go();
    feed_tile(TILE, -1);
    wait_drain();
    chk("post_rst_count", rx_q.size(), 16);
    chk("post_rst_first", rx_q[0], 32'h03020100);
    chk("post_rst_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_requant_pack.md
# acc_requant_pack

Downstream consumer of the 8x8 PE array's result drain stream. On each tile-done event it requests a drain and receives SIDE*SIDE int32 accumulators in row-major order. It applies per-column bias, fixed-point scale, rounding shift, zero-point and int8 saturation to each accumulator, then packs four results per 32-bit word into an output FIFO. The FIFO is read by the writeback DMA through a valid/ready port. The drain stream has no backpressure, so a drain is requested only when the FIFO can absorb a whole tile.

## Interface
- SIDE, 8, array side; SIDE*SIDE must be a multiple of 4
- ACC_BITS, 32, accumulator width
- FIFO_DEPTH, 16, output FIFO depth in words; must be >= SIDE*SIDE/4
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- tile_go  in  1  one-cycle pulse; tile results are ready in the array (driven from PE-array done)
- cfg_scale  in  16  signed multiplier; latched on tile acceptance
- cfg_shift  in  6  right shift, 0..47; latched on tile acceptance
- cfg_zp  in  8  signed output zero point; latched on tile acceptance
- bias_wr_en  in  1  write strobe for the bias table
- bias_wr_idx  in  $clog2(SIDE)  bias column index
- bias_wr_data  in  32  signed bias value
- c_drain_req  out  1  drain request to the array
- c_busy  in  1  array drain is in progress
- c_valid  in  1  accumulator beat is valid
- c_data  in  ACC_BITS  signed accumulator value
- c_last  in  1  final beat of the tile
- o_valid  out  1  output word is available
- o_ready  in  1  consumer accepts the word
- o_data  out  32  packed int8 results; element n of a group occupies byte n%4 (byte 0 first)
- o_last  out  1  word is the final word of its tile
- busy  out  1  FSM is not IDLE, or tile_go is pending
- err  out  1  sticky error flag; cleared only by reset

## Operation
- FSM states: IDLE, REQ, RECV, FLUSH.
- IDLE -> REQ when a tile is pending and FIFO free entries >= SIDE*SIDE/4. On this transition, cfg_* are latched and the pending flag clears.
- REQ: c_drain_req = 1, held until c_busy = 1 is sampled, then go to RECV.
- RECV: a column counter (0..SIDE-1) advances on every c_valid and wraps after SIDE-1. On c_valid with c_last, go to FLUSH.
- FLUSH: wait until the pipeline is empty and the final word has been pushed, then go to IDLE.
- tile_go sets a one-deep pending flag in any state. tile_go while already pending sets err; the extra pulse is dropped.
- c_valid outside RECV sets err; the beat is dropped.
- A beat count other than SIDE*SIDE at c_last sets err. The partial word is still flushed, padded with zero bytes, with o_last = 1.
- Arithmetic per beat:
  - s1 = c_data + bias[col], 33-bit signed.
  - s2 = s1 * cfg_scale, 49-bit signed.
  - If cfg_shift = 0, s3 = s2. Otherwise s3 = (s2 + 2^(cfg_shift-1)) >>> cfg_shift (round half up).
  - s4 = s3 + cfg_zp, then saturate to [-128, 127].
- Packing: a byte counter fills lanes 0..3. On lane 3, the word is pushed to the FIFO. o_last = 1 on the SIDE*SIDE/4-th word of the tile.
- bias_wr_en can be written at any time and takes effect on the next beat's stage 1. A write during RECV is legal; the consequences are software's responsibility.
- Output FIFO: standard valid/ready. A word transfers when o_valid && o_ready. o_data and o_last stay stable while o_valid && !o_ready.
- FIFO overflow cannot occur by construction. A push into a full FIFO sets err and the word is dropped (assertion target).

## Timing
- Reset values: c_drain_req = 0, o_valid = 0, o_data = 0, o_last = 0, busy = 0, err = 0. The FSM is IDLE, all counters are 0, the bias table is 0, the pending flag is 0, and the FIFO is empty.
- tile_go at cycle t, with room in the FIFO: REQ is entered and c_drain_req = 1 from t+1.
- Beat at cycle t: s1 is registered at t+1, s2 at t+2, s4 at t+3. If the beat fills lane 3, the word is written to the FIFO at t+3 and o_valid is high from t+4. Minimum latency from beat to o_valid is 4 cycles.
- Sustained throughput: 1 beat per cycle in, 1 word per 4 cycles out.
- Simultaneous FIFO push and pop: occupancy is unchanged. This is legal even when the FIFO is full if a pop occurs in the same cycle.
- Reset asserted mid-tile: all state is cleared immediately and the in-flight tile is discarded.

## Test plan
- Identity check. Set bias = 0, scale = 1, shift = 0, zp = 0, and feed c_data = n for n = 0..63. Required: 16 words; the first is 0x03020100 and the last is 0x3F3E3D3C with o_last = 1. The earliest o_valid is 4 cycles after beat 3.
- Rounding and saturation. Set scale = 3, shift = 2, zp = -5, and feed c_data values 5, -5, 1000, -1000.
  - The pre-zp results are round((5*3)/4) = 4 and round((-5*3)/4) = -4 (since -15 + 2 = -13, and -13 >>> 2 = -4).
  - Required bytes: 0xFF, 0xF7, 0x7F, 0x80.
- Bias per column. Set bias[c] = 10*c with identity scale, and feed c_data = 0. Required: row bytes 0, 10, ..., 70, repeated across all 8 rows.
- Backpressure. Hold o_ready = 0, send tile 1, then assert tile_go again. Required: no c_drain_req for tile 2 until at least 16 words are free. After o_ready = 1 and the FIFO drains, tile 2 is requested, and no word is lost or reordered.
- Protocol errors:
  - Two tile_go pulses while pending -> err = 1.
  - c_valid while IDLE -> err = 1 and no FIFO push.
  - c_last after 62 beats -> err = 1, the final word is 0x00003D3C, and o_last = 1.
- Reset mid-tile. Assert rstn low at beat 20. Required: all outputs return to their reset values. After release, a fresh tile produces exactly 16 correct words.
